// File: rtl/alpu_xtx_rd_arbiter_if.sv
// xtx read-port bundle: requester side and buffer side of the arbiter.
// slave = arbiter, master = requesters plus xtx buffer.
interface alpu_xtx_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) ();
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic                          rsp_miss_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic [ADDR_WIDTH-1:0]         buf_raddr_o;
  logic                          buf_rready_o;
  logic [DATA_WIDTH-1:0]         buf_rdata_i;
  logic                          buf_rvalid_i;

  modport slave (
    input  req_valid_i, req_addr_i,
    input  buf_rdata_i, buf_rvalid_i,
    output req_ready_o, rsp_valid_o,
    output rsp_miss_o, rsp_data_o,
    output buf_raddr_o, buf_rready_o
  );

  modport master (
    output req_valid_i, req_addr_i,
    output buf_rdata_i, buf_rvalid_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_miss_o, rsp_data_o,
    input  buf_raddr_o, buf_rready_o
  );
endinterface

// File: rtl/alpu_xtx_rd_arbiter.sv
// Round-robin arbiter for the xtx buffer read port, one read in flight.
// Optional stats counters: define ALPU_XTX_ARB_STATS_EN.
module alpu_xtx_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input logic clk,
  input logic reset_n,
  alpu_xtx_rd_arbiter_if.slave bus
`ifdef ALPU_XTX_ARB_STATS_EN
  ,
  output logic [15:0] stat_grants_o,
  output logic [15:0] stat_timeouts_o
`endif
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           rr_q, idx_q;
  logic [IW-1:0]           win, j;
  logic                    win_vld;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    miss_q;
  logic [7:0]              wait_q;
  logic                    accept, hit, tmo;
  logic [NUM_REQ-1:0]      ready, rsp_v;
  logic                    rready, rsp_m;
  logic [ADDR_WIDTH-1:0]   raddr;

  // Pick the first requester after rr_q; lowest offset assigned last wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    j       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(rr_q) + k) % NUM_REQ);
      if (bus.req_valid_i[j]) begin
        win     = j;
        win_vld = 1'b1;
      end
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_d = state_q;
    ready   = '0;
    rsp_v   = '0;
    rsp_m   = 1'b0;
    rready  = 1'b0;
    raddr   = '0;
    accept  = 1'b0;
    hit     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          ready[win] = 1'b1;
          accept     = 1'b1;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        rready = 1'b1;
        raddr  = addr_q;
        if (bus.buf_rvalid_i) begin
          hit     = 1'b1;
          state_d = RESP;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_v[idx_q] = 1'b1;
        rsp_m        = miss_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Transaction registers: winner, address, wait count, result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q   <= IW'(NUM_REQ - 1);
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      miss_q <= 1'b0;
      wait_q <= '0;
    end else begin
      if (accept) begin
        idx_q  <= win;
        addr_q <= bus.req_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        wait_q <= '0;
      end
      if (state_q == LOOKUP && !hit && !tmo)
        wait_q <= wait_q + 8'd1;
      if (hit) begin
        data_q <= bus.buf_rdata_i;
        miss_q <= 1'b0;
      end
      if (tmo) begin
        data_q <= '0;
        miss_q <= 1'b1;
      end
      if (state_q == RESP)
        rr_q <= idx_q;
    end
  end

  assign bus.req_ready_o  = reset_n ? ready  : '0;
  assign bus.rsp_valid_o  = reset_n ? rsp_v  : '0;
  assign bus.rsp_miss_o   = reset_n & rsp_m;
  assign bus.rsp_data_o   = reset_n ? data_q : '0;
  assign bus.buf_raddr_o  = reset_n ? raddr  : '0;
  assign bus.buf_rready_o = reset_n & rready;

`ifdef ALPU_XTX_ARB_STATS_EN
  logic [15:0] grants_q, tmos_q;

  // Saturating grant and timeout counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grants_q <= '0;
      tmos_q   <= '0;
    end else begin
      if (accept && grants_q != 16'hFFFF)
        grants_q <= grants_q + 16'd1;
      if (state_q == RESP && miss_q && tmos_q != 16'hFFFF)
        tmos_q <= tmos_q + 16'd1;
    end
  end

  assign stat_grants_o   = grants_q;
  assign stat_timeouts_o = tmos_q;
`endif
endmodule

// File: doc/alpu_xtx_rd_arbiter.md
Name: alpu_xtx_rd_arbiter

Overview:
- Shares the single interconnect read port of an exec unit's foreign TX buffer (xtx) among NUM_REQ remote requesters (other exec units).
- Round-robin arbitration, one transaction in flight.
- Drives the buffer read address and read-ready, waits for a hit with a bounded timeout, then returns data or a miss to the granted requester.
- Sits between the interconnect read channels and the xtx buffer inside each exec unit.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ADDR_WIDTH, 6, width of the interconnect operand address (eu_idx plus register index).
- DATA_WIDTH, 16, operand data width.
- TIMEOUT, 15, maximum LOOKUP cycles before a miss is reported; 1..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester read request.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready_o  out  NUM_REQ  one-hot accept; the request is taken when valid and ready are both high.
- rsp_valid_o  out  NUM_REQ  one-hot response strobe, one cycle wide.
- rsp_miss_o  out  1  qualifies rsp_valid_o; 1 = timeout, data invalid.
- rsp_data_o  out  DATA_WIDTH  response data, shared by all requesters.
- buf_raddr_o  out  ADDR_WIDTH  xtx buffer read address.
- buf_rready_o  out  1  xtx buffer read enable; a hit consumes the entry.
- buf_rdata_i  in  DATA_WIDTH  xtx buffer read data.
- buf_rvalid_i  in  1  xtx buffer hit, combinational from buf_raddr_o/buf_rready_o.

Behaviour:
- The FSM has three states: IDLE, LOOKUP, RESP. Reset returns to IDLE from any state, including mid-transaction; no response is emitted for an aborted transaction.
- Reset values:
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - Address/index/data registers cleared to 0; wait_cnt=0.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_miss_o, rsp_data_o, buf_raddr_o, buf_rready_o.
- IDLE:
  - Winner = first i with req_valid_i[i]=1, searching from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 combinationally in the same cycle; no other bit is set.
  - On acceptance, latch the winner's address and index, clear wait_cnt, and go to LOOKUP.
  - If there are no requests, stay in IDLE with req_ready_o=0.
- LOOKUP:
  - Drive buf_raddr_o = latched address, buf_rready_o=1. req_ready_o=0 for all requesters.
  - If buf_rvalid_i=1: capture buf_rdata_i into the data register, set miss=0, go to RESP.
  - Else increment wait_cnt. When wait_cnt reaches TIMEOUT-1 with no hit, set miss=1, clear the data register to 0, and go to RESP.
  - A hit on the final allowed cycle wins over the timeout.
- RESP:
  - rsp_valid_o[idx]=1, rsp_miss_o=miss, rsp_data_o=data register; buf_rready_o=0.
  - Set rr_ptr=idx and return to IDLE.
  - Outside RESP, rsp_valid_o=0 and rsp_miss_o=0; rsp_data_o holds its last value.
- Timing:
  - Minimum 3 cycles per transaction: accept at t, hit at t+1, response at t+2.
  - Maximum 2+TIMEOUT cycles.
  - Throughput is at most one transaction per 3 cycles.
- Requester rules:
  - A requester may drop req_valid_i before it is accepted; nothing is recorded.
  - A requester may re-request immediately after its response, but round-robin serves other pending requesters first.
- Simultaneous requests: only the round-robin winner is accepted. All others see ready=0 and must hold.
- Fairness: with all NUM_REQ requesting continuously, the grant order is strictly cyclic and the wait for any requester is bounded by (NUM_REQ-1)*(2+TIMEOUT) cycles.

Optional Feature:
- Macro: ALPU_XTX_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grants_o (16 bits) and stat_timeouts_o (16 bits).
  - stat_grants_o increments on each accepted request; stat_timeouts_o increments on each RESP with miss=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: no requests for 10 cycles -> all outputs 0, buf_rready_o=0.
- Single hit: req_valid_i=4'b0100, requester 2 addr=6'h15, buffer hits at first LOOKUP with data 16'hBEEF -> req_ready_o=4'b0100 at t, buf_raddr_o=6'h15 at t+1, rsp_valid_o=4'b0100, rsp_miss_o=0, rsp_data_o=16'hBEEF at t+2.
- Round robin: all four request continuously, buffer always hits -> grants in order 0,1,2,3,0, each 3 cycles apart.
- Timeout: requester 1 requests, buf_rvalid_i held 0 -> exactly 15 LOOKUP cycles, then rsp_valid_o=4'b0010, rsp_miss_o=1, rsp_data_o=0.
- Late hit: buf_rvalid_i first rises on LOOKUP cycle 15 with data 16'h0042 -> rsp_miss_o=0, rsp_data_o=16'h0042.
- Reset mid-transaction: assert reset_n=0 in LOOKUP -> next cycle state=IDLE, no rsp_valid_o; after release, requester 0 wins first.
